packet_assembler: RTL

- Byte-serial receiver that builds the 152-bit operand packet consumed by the adder datapath.
- Hunts for a 16-bit header, collects two 64-bit operands MSB-first, and verifies an XOR checksum byte.
- Presents the completed packet on a valid/ready output; the adder reads its operands from packet[135:72] and packet[71:8].
- Packet layout: [151:136] header, [135:72] operand A, [71:8] operand B, [7:0] checksum.

---
 rtl/packet_assembler_pkg.sv | 26 ++
 rtl/packet_assembler_xor_accum.sv | 32 +++
 rtl/packet_assembler.sv | 114 +++++++++++
 3 files changed

// File: rtl/packet_assembler_pkg.sv
// Shared definitions for the byte-serial operand packet format:
// width, sync word, field slices and receiver states.
package packet_assembler_pkg;

  localparam int PKT_W         = 152;
  localparam logic [15:0] HEADER = 16'hA55A;
  localparam int PAYLOAD_BYTES = 16;

  localparam int HDR_MSB = 151;
  localparam int HDR_LSB = 136;
  localparam int A_MSB   = 135;
  localparam int A_LSB   = 72;
  localparam int B_MSB   = 71;
  localparam int B_LSB   = 8;
  localparam int CK_MSB  = 7;
  localparam int CK_LSB  = 0;

  typedef enum logic [2:0] {
    HUNT0   = 3'd0,
    HUNT1   = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    HOLD    = 3'd4
  } state_e;

endpackage

// File: rtl/packet_assembler_xor_accum.sv
// 8-bit running XOR with clear/load/enable; shared with the transmit-side packetizer.
// Priority is clear, then load, then accumulate.
module pkt_xor_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_d, acc_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (clr)       acc_d = 8'h00;
    else if (load) acc_d = load_val;
    else if (en)   acc_d = acc_q ^ din;
  end

  // NOTE: state is updated with non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= 8'h00;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/packet_assembler.sv
// Byte-serial receiver: hunts for the sync word, collects operands A and B
// MSB-first, verifies the XOR checksum and holds the packet on a valid/ready port.
module packet_assembler
  import packet_assembler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PKT_W-1:0] packet,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic             err_checksum
);

  localparam int OPS_W = A_MSB - B_LSB + 1;

  state_e           state_d, state_q;
  logic [3:0]       cnt_d, cnt_q;
  logic [OPS_W-1:0] ops_d, ops_q;
  logic [PKT_W-1:0] packet_d, packet_q;
  logic             err_d, err_q;

  logic       accept;
  logic       acc_clr, acc_load, acc_en;
  logic [7:0] acc;

  assign accept = in_valid && in_ready;

  pkt_xor_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .load     (acc_load),
    .load_val (HEADER[15:8]),
    .en       (acc_en),
    .din      (in_data),
    .acc      (acc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    packet_d = packet_q;
    err_d    = 1'b0;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;

    unique case (state_q)
      HUNT0: if (accept && in_data == HEADER[15:8]) begin
        acc_load = 1'b1;
        state_d  = HUNT1;
      end
      HUNT1: if (accept) begin
        if (in_data == HEADER[7:0]) begin
          acc_en  = 1'b1;
          cnt_d   = 4'd0;
          state_d = PAYLOAD;
        end else if (in_data == HEADER[15:8]) begin
          // Overlapping resync: a repeated high sync byte restarts the match.
          acc_load = 1'b1;
        end else begin
          acc_clr = 1'b1;
          state_d = HUNT0;
        end
      end
      PAYLOAD: if (accept) begin
        ops_d  = {ops_q[OPS_W-9:0], in_data};
        acc_en = 1'b1;
        if (cnt_q == 4'(PAYLOAD_BYTES - 1)) state_d = CHECK;
        else                                cnt_d   = cnt_q + 4'd1;
      end
      CHECK: if (accept) begin
        acc_clr = 1'b1;
        if (in_data == acc) begin
          packet_d[HDR_MSB:HDR_LSB] = HEADER;
          packet_d[A_MSB:B_LSB]     = ops_q;
          packet_d[CK_MSB:CK_LSB]   = in_data;
          state_d                   = HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = HUNT0;
        end
      end
      HOLD: if (pkt_ready) state_d = HUNT0;
      default: state_d = HUNT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT0;
      cnt_q    <= 4'd0;
      ops_q    <= '0;
      packet_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ops_q    <= ops_d;
      packet_q <= packet_d;
      err_q    <= err_d;
    end
  end

  assign in_ready     = (state_q != HOLD);
  assign pkt_valid    = (state_q == HOLD);
  assign packet       = packet_q;
  assign err_checksum = err_q;

endmodule
